// File: rtl/sc_config_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sc_config_sequencer_if
// Purpose  : Host configuration bus (write/read/commit) for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface sc_config_sequencer_if;
    logic        cfg_wr_i;
    logic        cfg_rd_i;
    logic [3:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic        commit_i;

    modport master (
        output cfg_wr_i, cfg_rd_i, cfg_addr_i, cfg_wdata_i, commit_i,
        input  cfg_rdata_o
    );

    modport slave (
        input  cfg_wr_i, cfg_rd_i, cfg_addr_i, cfg_wdata_i, commit_i,
        output cfg_rdata_o
    );
endinterface
`default_nettype wire

// File: rtl/sc_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sc_config_sequencer
// Purpose  : Shadow/active config bank with frame-boundary atomic apply and
//            resync-based frame lock monitor.
// Revision : 1.0 - initial release
// ============================================================================
module sc_config_sequencer #(
    parameter int unsigned LOCK_FRAMES    = 8,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4194304
) (
    input  wire logic               PCLK_OUT_i,
    input  wire logic               reset_i,
    sc_config_sequencer_if.slave    cfg_bus,
    input  wire logic               VSYNC_i,
    input  wire logic               resync_strobe_i,
    output logic [31:0]             h_out_config_o,
    output logic [31:0]             h_out_config2_o,
    output logic [31:0]             v_out_config_o,
    output logic [31:0]             v_out_config2_o,
    output logic [31:0]             xy_out_config_o,
    output logic [31:0]             misc_config_o,
    output logic [31:0]             sl_config_o,
    output logic [31:0]             sl_config2_o,
    output logic                    testpattern_enable_o,
    output logic                    cfg_busy_o,
    output logic                    applied_o,
    output logic                    locked_o,
    output logic                    timeout_o,
    output logic                    wr_err_o,
    output logic [7:0]              resync_cnt_o
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_PENDING  = 2'd1;
    localparam logic [1:0]  c_APPLY    = 2'd2;
    localparam logic [7:0]  c_LOCK_MAX = 8'(LOCK_FRAMES);
    localparam logic [23:0] c_TMO_LAST = TIMEOUT_CYCLES - 24'd1;
    localparam logic [3:0]  c_CTRL_ADR = 4'd8;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [7:0][31:0]  r_shadow;
    logic              r_shadow_tp;
    logic [7:0][31:0]  r_active;
    logic              r_active_tp;
    logic [23:0]       r_tmo_cnt;
    logic              r_busy;
    logic              r_applied;
    logic              r_timeout;
    logic              r_wr_err;
    logic              r_locked;
    logic [7:0]        r_lock_cnt;
    logic [7:0]        r_resync_cnt;
    logic              r_vs_prev;
    logic              r_rs_prev;
    logic [31:0]       r_rdata;

    logic              w_boundary;
    logic              w_rs_rise;
    logic              w_tmo_hit;
    logic              w_busy_nxt;
    logic              w_do_apply;
    logic              w_leave_pending;
    logic              w_wr_valid;
    logic              w_wr_take;
    logic              w_wr_clr;
    logic [7:0]        w_lock_nxt;
    logic [31:0]       w_rd_mux;

    assign w_boundary = r_vs_prev & ~VSYNC_i;
    assign w_rs_rise  = resync_strobe_i & ~r_rs_prev;
    assign w_tmo_hit  = (r_tmo_cnt == c_TMO_LAST);

    // State register
    always_ff @(posedge PCLK_OUT_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the boundary and the timeout lead to the same state,
    // only the timeout flag distinguishes them.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (cfg_bus.commit_i)          w_next_state = c_PENDING;
            c_PENDING: if (w_boundary || w_tmo_hit)   w_next_state = c_APPLY;
            c_APPLY:                                  w_next_state = c_IDLE;
            default:                                  w_next_state = c_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_busy_nxt      = (w_next_state != c_IDLE);
        w_do_apply      = (r_state == c_APPLY);
        w_leave_pending = (r_state == c_PENDING) && (w_next_state == c_APPLY);
    end

    assign w_wr_valid = cfg_bus.cfg_wr_i && (cfg_bus.cfg_addr_i <= c_CTRL_ADR);
    assign w_wr_take  = w_wr_valid && !r_busy;
    assign w_wr_clr   = cfg_bus.cfg_wr_i && (cfg_bus.cfg_addr_i == c_CTRL_ADR)
                        && cfg_bus.cfg_wdata_i[31];

    always_comb begin
        w_rd_mux = '0;
        if (!cfg_bus.cfg_addr_i[3]) begin
            w_rd_mux = r_shadow[cfg_bus.cfg_addr_i[2:0]];
        end else if (cfg_bus.cfg_addr_i == c_CTRL_ADR) begin
            w_rd_mux = {r_wr_err, r_timeout, r_locked, r_busy, 16'h0,
                        r_resync_cnt, 3'b000, r_shadow_tp};
        end
    end

    always_comb begin
        w_lock_nxt = r_lock_cnt;
        if (w_rs_rise) begin
            w_lock_nxt = 8'd0;
        end else if (w_boundary && (r_lock_cnt != c_LOCK_MAX)) begin
            w_lock_nxt = r_lock_cnt + 8'd1;
        end
    end

    always_ff @(posedge PCLK_OUT_i or posedge reset_i) begin
        if (reset_i) begin
            r_shadow     <= '0;
            r_shadow_tp  <= 1'b0;
            r_active     <= '0;
            r_active_tp  <= 1'b0;
            r_tmo_cnt    <= '0;
            r_busy       <= 1'b0;
            r_applied    <= 1'b0;
            r_timeout    <= 1'b0;
            r_wr_err     <= 1'b0;
            r_locked     <= 1'b0;
            r_lock_cnt   <= '0;
            r_resync_cnt <= '0;
            r_vs_prev    <= 1'b1;
            r_rs_prev    <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_vs_prev <= VSYNC_i;
            r_rs_prev <= resync_strobe_i;
            r_busy    <= w_busy_nxt;
            r_applied <= w_do_apply;

            if (w_wr_take && !cfg_bus.cfg_addr_i[3]) begin
                r_shadow[cfg_bus.cfg_addr_i[2:0]] <= cfg_bus.cfg_wdata_i;
            end
            if (w_wr_take && (cfg_bus.cfg_addr_i == c_CTRL_ADR)) begin
                r_shadow_tp <= cfg_bus.cfg_wdata_i[0];
            end

            // The clear request still lands when the write itself is dropped.
            if (w_wr_valid && r_busy) begin
                r_wr_err <= 1'b1;
            end
            if (w_wr_clr) begin
                r_wr_err <= 1'b0;
            end

            if (cfg_bus.cfg_rd_i) begin
                r_rdata <= w_rd_mux;
            end

            if (r_state == c_PENDING) begin
                r_tmo_cnt <= r_tmo_cnt + 24'd1;
            end else begin
                r_tmo_cnt <= '0;
            end

            if (w_leave_pending) begin
                r_timeout <= ~w_boundary;
            end

            if (w_do_apply) begin
                r_active    <= r_shadow;
                r_active_tp <= r_shadow_tp;
            end

            r_lock_cnt <= w_lock_nxt;
            r_locked   <= (w_lock_nxt == c_LOCK_MAX);
            if (w_rs_rise && (r_resync_cnt != 8'hFF)) begin
                r_resync_cnt <= r_resync_cnt + 8'd1;
            end
        end
    end

    assign cfg_bus.cfg_rdata_o  = r_rdata;
    assign h_out_config_o       = r_active[0];
    assign h_out_config2_o      = r_active[1];
    assign v_out_config_o       = r_active[2];
    assign v_out_config2_o      = r_active[3];
    assign xy_out_config_o      = r_active[4];
    assign misc_config_o        = r_active[5];
    assign sl_config_o          = r_active[6];
    assign sl_config2_o         = r_active[7];
    assign testpattern_enable_o = r_active_tp;
    assign cfg_busy_o           = r_busy;
    assign applied_o            = r_applied;
    assign locked_o             = r_locked;
    assign timeout_o            = r_timeout;
    assign wr_err_o             = r_wr_err;
    assign resync_cnt_o         = r_resync_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sc_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sc_config_sequencer
// Purpose  : Scoreboard bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_config_sequencer;

    localparam int          LF  = 3;
    localparam logic [23:0] TMO = 24'd16;

    typedef struct packed {
        logic [31:0]      cyc;
        logic [7:0][31:0] w;
        logic             tp;
        logic             tmo;
    } apply_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vsync = 1'b1;
    logic rs = 1'b0;
    always #5 clk = ~clk;

    sc_config_sequencer_if bus();

    logic [31:0] h, h2, v, v2, xy, misc, sl, sl2;
    logic        tp_o, busy_o, applied_o, locked_o, timeout_o, wr_err_o;
    logic [7:0]  rcnt_o;

    sc_config_sequencer #(.LOCK_FRAMES(LF), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK_OUT_i(clk), .reset_i(rst), .cfg_bus(bus),
        .VSYNC_i(vsync), .resync_strobe_i(rs),
        .h_out_config_o(h), .h_out_config2_o(h2), .v_out_config_o(v),
        .v_out_config2_o(v2), .xy_out_config_o(xy), .misc_config_o(misc),
        .sl_config_o(sl), .sl_config2_o(sl2), .testpattern_enable_o(tp_o),
        .cfg_busy_o(busy_o), .applied_o(applied_o), .locked_o(locked_o),
        .timeout_o(timeout_o), .wr_err_o(wr_err_o), .resync_cnt_o(rcnt_o)
    );

    // Reference model: values visible during the current cycle.
    logic [7:0][31:0] m_shadow, m_active;
    logic  m_tp, m_act_tp, m_timeout, m_wr_err, m_vs_prev, m_rs_prev;
    bit    m_waiting, m_apply_next;
    int    m_waited, m_lock, m_rcnt, m_cyc;

    logic [7:0][31:0] e_active;
    logic  e_tp, e_busy, e_locked, e_timeout, e_wr_err;
    logic [7:0] e_rcnt;
    int    e_cyc;

    logic [31:0] rdq[$];
    apply_t      apq[$];
    logic        chk_en = 1'b0;
    logic        rd_seen = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic model_reset();
        m_shadow = '0; m_active = '0; m_tp = 0; m_act_tp = 0;
        m_timeout = 0; m_wr_err = 0; m_vs_prev = 1; m_rs_prev = 0;
        m_waiting = 0; m_apply_next = 0; m_waited = 0;
        m_lock = 0; m_rcnt = 0;
    endtask

    task automatic step(input logic wr, input logic rd, input logic [3:0] addr,
                        input logic [31:0] wd, input logic cm,
                        input logic vs, input logic rsv);
        bit bnd, rise, busy;
        apply_t ap;
        bus.cfg_wr_i = wr; bus.cfg_rd_i = rd; bus.cfg_addr_i = addr;
        bus.cfg_wdata_i = wd; bus.commit_i = cm; vsync = vs; rs = rsv;

        busy      = m_waiting || m_apply_next;
        e_active  = m_active; e_tp = m_act_tp; e_busy = busy;
        e_locked  = (m_lock == LF); e_timeout = m_timeout;
        e_wr_err  = m_wr_err; e_rcnt = m_rcnt[7:0]; e_cyc = m_cyc;
        chk_en    = 1'b1;

        bnd  = m_vs_prev && !vs;
        rise = rsv && !m_rs_prev;

        if (rd) begin
            if (addr < 8)       rdq.push_back(m_shadow[addr[2:0]]);
            else if (addr == 8) rdq.push_back({m_wr_err, m_timeout, e_locked, busy,
                                               16'h0, m_rcnt[7:0], 3'b000, m_tp});
            else                rdq.push_back(32'h0);
        end

        if (wr && addr <= 8) begin
            if (busy)           m_wr_err = 1;
            else if (addr < 8)  m_shadow[addr[2:0]] = wd;
            else                m_tp = wd[0];
            if (addr == 8 && wd[31]) m_wr_err = 0;
        end

        if (m_apply_next) begin
            m_active = m_shadow; m_act_tp = m_tp; m_apply_next = 0;
            ap.cyc = m_cyc + 1; ap.w = m_shadow; ap.tp = m_tp; ap.tmo = m_timeout;
            apq.push_back(ap);
        end else if (m_waiting) begin
            if (bnd) begin
                m_timeout = 0; m_waiting = 0; m_apply_next = 1;
            end else if (m_waited == int'(TMO) - 1) begin
                m_timeout = 1; m_waiting = 0; m_apply_next = 1;
            end else begin
                m_waited++;
            end
        end else if (cm) begin
            m_waiting = 1; m_waited = 0;
        end

        if (rise) begin
            m_lock = 0;
            if (m_rcnt < 255) m_rcnt++;
        end else if (bnd && m_lock < LF) begin
            m_lock++;
        end

        m_vs_prev = vs; m_rs_prev = rsv; m_cyc++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k, input logic vs);
        for (int i = 0; i < k; i++) step(0, 0, 4'd0, 32'h0, 0, vs, 0);
    endtask

    always @(posedge clk) rd_seen <= bus.cfg_rd_i;

    // Monitor: status every cycle, read data one cycle after a read, applies on pulse.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0][31:0] act;
            bit due;
            act = {sl2, sl, misc, xy, v2, v, h2, h};
            n_cmp++;
            if (act !== e_active || tp_o !== e_tp || busy_o !== e_busy ||
                locked_o !== e_locked || timeout_o !== e_timeout ||
                wr_err_o !== e_wr_err || rcnt_o !== e_rcnt) begin
                n_fail++;
                $display("FAIL status @%0d got act=%h tp=%b busy=%b lock=%b tmo=%b err=%b rcnt=%0d want act=%h tp=%b busy=%b lock=%b tmo=%b err=%b rcnt=%0d",
                         e_cyc, act, tp_o, busy_o, locked_o, timeout_o, wr_err_o, rcnt_o,
                         e_active, e_tp, e_busy, e_locked, e_timeout, e_wr_err, e_rcnt);
            end

            if (rd_seen) begin
                n_cmp++;
                if (rdq.size() == 0) begin
                    n_fail++;
                    $display("FAIL rdata @%0d got %h want <no read queued>", e_cyc, bus.cfg_rdata_o);
                end else begin
                    logic [31:0] exp_rd;
                    exp_rd = rdq.pop_front();
                    if (bus.cfg_rdata_o !== exp_rd) begin
                        n_fail++;
                        $display("FAIL rdata @%0d got %h want %h", e_cyc, bus.cfg_rdata_o, exp_rd);
                    end
                end
            end

            due = (apq.size() > 0) && (apq[0].cyc == 32'(e_cyc));
            if (due || applied_o) begin
                n_cmp++;
                if (!(due && applied_o === 1'b1)) begin
                    n_fail++;
                    $display("FAIL applied @%0d got %b want %b", e_cyc, applied_o, due);
                end else if (act !== apq[0].w || tp_o !== apq[0].tp || timeout_o !== apq[0].tmo) begin
                    n_fail++;
                    $display("FAIL apply_bank @%0d got %h/%b/%b want %h/%b/%b", e_cyc,
                             act, tp_o, timeout_o, apq[0].w, apq[0].tp, apq[0].tmo);
                end
                if (due) void'(apq.pop_front());
            end
        end
    end

    initial begin
        logic cur_vs;
        bus.cfg_wr_i = 0; bus.cfg_rd_i = 0; bus.cfg_addr_i = 0;
        bus.cfg_wdata_i = 0; bus.commit_i = 0;
        model_reset();
        m_cyc = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Shadow writes and readback; active stays zero
        step(1, 0, 4'd0, 32'h0000_0C80, 0, 1, 0);
        step(1, 0, 4'd7, 32'h1234_5678, 0, 1, 0);
        step(0, 1, 4'd0, 32'h0, 0, 1, 0);
        step(0, 1, 4'd7, 32'h0, 0, 1, 0);
        step(0, 1, 4'd8, 32'h0, 0, 1, 0);
        step(0, 1, 4'd12, 32'h0, 0, 1, 0);
        idle(2, 1);

        // Commit, dropped write while pending, error clear, boundary apply
        step(0, 0, 4'd0, 32'h0, 1, 1, 0);
        idle(3, 1);
        step(1, 0, 4'd2, 32'hDEAD_BEEF, 0, 1, 0);
        step(0, 1, 4'd2, 32'h0, 0, 1, 0);
        step(0, 1, 4'd8, 32'h0, 0, 1, 0);
        step(1, 0, 4'd8, 32'h8000_0000, 0, 1, 0);
        idle(3, 1);
        idle(4, 0);
        idle(2, 1);

        // Forced apply by timeout, then cleared by a boundary apply
        step(1, 0, 4'd8, 32'h0000_0001, 1, 1, 0);
        idle(22, 1);
        step(0, 0, 4'd0, 32'h0, 1, 1, 0);
        idle(3, 1);
        idle(4, 0);
        idle(2, 1);

        // Lock acquisition and loss on a coincident resync rise
        for (int i = 0; i < 3; i++) begin
            idle(1, 1);
            idle(1, 0);
        end
        idle(2, 1);
        step(0, 0, 4'd0, 32'h0, 0, 0, 1);
        idle(3, 0);

        // Randomized traffic
        cur_vs = 1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] wd;
            if ($urandom_range(0, 5) == 0) cur_vs = ~cur_vs;
            wd = $urandom;
            wd[31] = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 4'($urandom_range(0, 15)), wd, $urandom_range(0, 9) == 0,
                 cur_vs, $urandom_range(0, 15) == 0);
        end
        idle(4, 1);

        // Asynchronous reset in the middle of a pending commit
        step(1, 0, 4'd0, 32'hCAFE_0001, 0, 1, 0);
        step(0, 0, 4'd0, 32'h0, 1, 1, 0);
        idle(4, 1);
        #1;
        rst = 1; chk_en = 0;
        bus.cfg_wr_i = 0; bus.cfg_rd_i = 0; bus.commit_i = 0;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || {sl2, sl, misc, xy, v2, v, h2, h} !== '0 ||
            tp_o !== 1'b0 || applied_o !== 1'b0 || rcnt_o !== 8'h0) begin
            n_fail++;
            $display("FAIL async_reset got busy=%b h=%h tp=%b applied=%b rcnt=%0d want all 0",
                     busy_o, h, tp_o, applied_o, rcnt_o);
        end
        model_reset();
        apq.delete();
        rdq.delete();
        @(posedge clk); #1;
        rst = 0;
        idle(2, 1);
        idle(3, 0);
        idle(2, 1);
        idle(20, 1);

        chk_en = 0;
        n_cmp++;
        if (apq.size() != 0 || rdq.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d applies/%0d reads outstanding want 0/0",
                     apq.size(), rdq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
